// File: rtl/io_irq_controller.sv
// Memory-mapped interrupt controller: masks device level lines, arbitrates one winner,
// runs a req/ack handshake and blocks until EOI. Define IRQ_ROUND_ROBIN_EN for rotating priority.
module io_irq_controller #(
  parameter int                    BITS       = 32,
  parameter int                    NUM_SRC    = 4,
  parameter logic [BITS-1:0]       ID_ADDR    = 32'hF0000900,
  parameter logic [BITS-1:0]       MASK_ADDR  = 32'hF0000904,
  parameter logic [BITS-1:0]       EOI_ADDR   = 32'hF0000908,
  parameter logic [NUM_SRC-1:0]    MASK_RESET = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic               re,
  input  logic [BITS-1:0]    memAddr,
  input  logic [BITS-1:0]    dataBusIn,
  output logic [BITS-1:0]    dataBusOut,
  input  logic [NUM_SRC-1:0] devIrq,
  output logic               intReq,
  input  logic               intAck,
  output logic [7:0]         intId
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           cur_id_q, cur_id_d;
  logic [NUM_SRC-1:0]   mask_q, mask_d;
  logic                 eoi_err_q, eoi_err_d;
`ifdef IRQ_ROUND_ROBIN_EN
  logic [7:0]           rr_ptr_q, rr_ptr_d;
`endif

  logic [NUM_SRC-1:0]   eligible;
  logic [NUM_SRC-1:0]   cur_sel;
  logic                 cur_live;
  logic [7:0]           winner;
  logic                 rd_strobe;
  logic                 rd_id;
  logic                 rd_mask;
  logic                 wr_mask;
  logic                 wr_eoi;
  logic                 busy;
  logic                 unused_bits;

  function automatic logic [7:0] pick_fixed(input logic [NUM_SRC-1:0] elig);
    logic [7:0] win;
    win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) win = 8'(i);
    end
    return win;
  endfunction

`ifdef IRQ_ROUND_ROBIN_EN
  // Scan upward from the pointer, wrapping, and keep the first hit.
  function automatic logic [7:0] pick_rr(input logic [NUM_SRC-1:0] elig,
                                         input logic [7:0] ptr);
    logic [7:0]         win;
    logic               found;
    logic [NUM_SRC-1:0] sh;
    int                 idx;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = (int'(ptr) + i) % NUM_SRC;
      sh  = elig >> idx;
      if (!found && sh[0]) begin
        win   = 8'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction
`endif

  assign eligible  = devIrq & mask_q;
  assign cur_sel   = NUM_SRC'(1) << cur_id_q;
  assign cur_live  = |(eligible & cur_sel);
  assign rd_strobe = re & ~we;
  assign rd_id     = rd_strobe && (memAddr == ID_ADDR);
  assign rd_mask   = rd_strobe && (memAddr == MASK_ADDR);
  assign wr_mask   = we && (memAddr == MASK_ADDR);
  assign wr_eoi    = we && (memAddr == EOI_ADDR);
  assign busy      = (state_q == REQ) || (state_q == SERVICE);
  assign unused_bits = ^dataBusIn;

`ifdef IRQ_ROUND_ROBIN_EN
  assign winner = pick_rr(eligible, rr_ptr_q);
`else
  assign winner = pick_fixed(eligible);
`endif

  always_comb begin
    state_d   = state_q;
    cur_id_d  = cur_id_q;
    mask_d    = mask_q;
    eoi_err_d = eoi_err_q;
`ifdef IRQ_ROUND_ROBIN_EN
    rr_ptr_d  = rr_ptr_q;
`endif
    if (wr_mask) mask_d = dataBusIn[NUM_SRC-1:0];
    // Read-clear comes first so an EOI mismatch in the same cycle still sets the flag.
    if (rd_id) eoi_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          cur_id_d = winner;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (intAck) state_d = SERVICE;
        else if (!cur_live) state_d = IDLE;
      end
      SERVICE: begin
        if (wr_eoi) begin
          if (dataBusIn[7:0] == cur_id_q) begin
            state_d = HOLD;
`ifdef IRQ_ROUND_ROBIN_EN
            rr_ptr_d = (cur_id_q == 8'(NUM_SRC - 1)) ? 8'd0 : cur_id_q + 8'd1;
`endif
          end else begin
            eoi_err_d = 1'b1;
          end
        end
      end
      HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cur_id_q  <= '0;
      mask_q    <= MASK_RESET;
      eoi_err_q <= 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
      rr_ptr_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cur_id_q  <= cur_id_d;
      mask_q    <= mask_d;
      eoi_err_q <= eoi_err_d;
`ifdef IRQ_ROUND_ROBIN_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
    end
  end

  assign intReq = (state_q == REQ);
  assign intId  = cur_id_q;

  always_comb begin
    dataBusOut = '0;
    if (rd_id) begin
      dataBusOut[7:0] = cur_id_q;
      dataBusOut[8]   = busy;
      dataBusOut[9]   = eoi_err_q;
    end else if (rd_mask) begin
      dataBusOut[NUM_SRC-1:0] = mask_q;
    end
  end

endmodule

// File: tb/tb_io_irq_controller.sv
// Scoreboard bench for io_irq_controller: expected values are queued as stimulus is
// driven and popped when the corresponding DUT output is sampled.
module tb_io_irq_controller;

  localparam logic [31:0] ID_A   = 32'hF0000900;
  localparam logic [31:0] MASK_A = 32'hF0000904;
  localparam logic [31:0] EOI_A  = 32'hF0000908;

  logic        clk = 1'b0;
  logic        reset, we, re, intAck, intReq;
  logic [31:0] memAddr, dataBusIn, dataBusOut;
  logic [3:0]  devIrq;
  logic [7:0]  intId;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  io_irq_controller dut (
    .clk(clk), .reset(reset), .we(we), .re(re), .memAddr(memAddr),
    .dataBusIn(dataBusIn), .dataBusOut(dataBusOut), .devIrq(devIrq),
    .intReq(intReq), .intAck(intAck), .intId(intId)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop_check(input logic [31:0] got);
    if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else chk(tag_q.pop_front(), got, exp_q.pop_front());
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    memAddr = a; dataBusIn = d; we = 1'b1;
    cyc();
    we = 1'b0; memAddr = '0; dataBusIn = '0;
  endtask

  task automatic read_expect(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    sb_push(tag, exp);
    memAddr = a; re = 1'b1;
    #2 d = dataBusOut;
    cyc();
    re = 1'b0; memAddr = '0;
    sb_pop_check(d);
  endtask

  task automatic wait_req(input string tag, output int n);
    n = 0;
    while (!intReq && n < 20) begin
      cyc();
      n++;
    end
    chk({tag, "_req"}, {31'd0, intReq}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hits;
    logic [7:0] id;
    reset = 1'b1; we = 1'b0; re = 1'b0; intAck = 1'b0;
    memAddr = '0; dataBusIn = '0; devIrq = 4'b0010;
    cyc(); cyc();
    reset = 1'b0;

    // Masked source must never request.
    chk("rst_intid", {24'd0, intId}, 32'd0);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (intReq) hits++;
    end
    chk("masked_no_req", hits, 0);
    read_expect("rst_id_rd", ID_A, 32'h0);
    read_expect("rst_mask_rd", MASK_A, 32'h0);

    // Mask write, arbitration, ack, EOI, next winner.
    devIrq = 4'b0110;
    bus_write(MASK_A, 32'h0000_000F);
    chk("mask_lat_0", {31'd0, intReq}, 32'd0);
    cyc();
    chk("mask_lat_1", {31'd0, intReq}, 32'd1);
    chk("first_id", {24'd0, intId}, 32'd1);
    read_expect("mask_rd", MASK_A, 32'hF);
    intAck = 1'b1; cyc(); intAck = 1'b0;
    chk("ack_drop", {31'd0, intReq}, 32'd0);
    read_expect("svc_id_rd", ID_A, 32'h101);
    devIrq = 4'b0100;
    bus_write(EOI_A, 32'd1);
    wait_req("after_eoi", n);
    chk("hold_latency", n, 2);
    chk("second_id", {24'd0, intId}, 32'd2);

    // EOI mismatch sets error, read clears it.
    intAck = 1'b1; cyc(); intAck = 1'b0;
    bus_write(EOI_A, 32'd3);
    read_expect("eoi_err_rd", ID_A, 32'h302);
    read_expect("eoi_err_clr", ID_A, 32'h102);
    read_expect("eoi_addr_rd", EOI_A, 32'h0);
    devIrq = 4'b0000;
    bus_write(EOI_A, 32'd2);
    cyc(); cyc();
    read_expect("idle_id_rd", ID_A, 32'h002);

    // Cancel by device line drop, then ack wins over same-cycle drop.
    devIrq = 4'b0001;
    wait_req("cancel", n);
    chk("cancel_id", {24'd0, intId}, 32'd0);
    devIrq = 4'b0000;
    cyc();
    chk("cancel_drop", {31'd0, intReq}, 32'd0);
    read_expect("cancel_id_rd", ID_A, 32'h000);
    devIrq = 4'b0001;
    wait_req("ackwin", n);
    devIrq = 4'b0000; intAck = 1'b1;
    cyc();
    intAck = 1'b0;
    chk("ackwin_noreq", {31'd0, intReq}, 32'd0);
    read_expect("ackwin_id_rd", ID_A, 32'h100);

    // Reset mid-service.
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("rst_svc_req", {31'd0, intReq}, 32'd0);
    read_expect("rst_svc_mask", MASK_A, 32'h0);
    read_expect("rst_svc_id", ID_A, 32'h0);
    intAck = 1'b1; cyc(); intAck = 1'b0;
    bus_write(ID_A, 32'h3FF);
    read_expect("idle_ack_ign", ID_A, 32'h0);

    // Arbitration order with all sources held.
    bus_write(MASK_A, 32'hF);
    devIrq = 4'b1111;
`ifdef IRQ_ROUND_ROBIN_EN
    sb_push("seq0", 32'd0); sb_push("seq1", 32'd1); sb_push("seq2", 32'd2);
    sb_push("seq3", 32'd3); sb_push("seq4", 32'd0);
`else
    sb_push("seq0", 32'd0); sb_push("seq1", 32'd0); sb_push("seq2", 32'd0);
    sb_push("seq3", 32'd0); sb_push("seq4", 32'd0);
`endif
    for (int k = 0; k < 5; k++) begin
      wait_req("seq", n);
      id = intId;
      sb_pop_check({24'd0, id});
      intAck = 1'b1; cyc(); intAck = 1'b0;
      bus_write(EOI_A, {24'd0, id});
    end
    chk("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
